// File: rtl/mult_booth32.sv
// Sequential radix-2 Booth multiplier, 32x32 signed -> low 32 product bits plus overflow flag.
// Contains the cla_32 carry-lookahead adder that forms the accumulator's low word each cycle.

module cla_32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);
    localparam int unsigned W  = 32;
    localparam int unsigned GW = 4;
    localparam int unsigned NG = W / GW;

    logic [W-1:0]  g;
    logic [W-1:0]  p;
    logic [W:0]    c;
    logic [NG-1:0] gg;
    logic [NG-1:0] gp;
    logic [NG:0]   gc;

    // Two-level lookahead: 4-bit group generate/propagate, then group carries.
    always_comb begin
        g  = a & b;
        p  = a ^ b;
        gg = '0;
        gp = '0;
        gc = '0;
        c  = '0;
        for (int k = 0; k < NG; k++) begin
            gg[k] = g[GW*k+3]
                  | (p[GW*k+3] & g[GW*k+2])
                  | (p[GW*k+3] & p[GW*k+2] & g[GW*k+1])
                  | (p[GW*k+3] & p[GW*k+2] & p[GW*k+1] & g[GW*k]);
            gp[k] = &p[GW*k +: GW];
        end
        gc[0] = cin;
        for (int k = 0; k < NG; k++) begin
            gc[k+1] = gg[k] | (gp[k] & gc[k]);
        end
        for (int k = 0; k < NG; k++) begin
            c[GW*k] = gc[k];
            for (int i = 0; i < GW - 1; i++) begin
                c[GW*k+i+1] = g[GW*k+i] | (p[GW*k+i] & c[GW*k+i]);
            end
        end
        c[W] = gc[NG];
        sum  = p ^ c[W-1:0];
        cout = c[W];
    end
endmodule

module mult_booth32 (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] data_operandA,
    input  logic [31:0] data_operandB,
    output logic        busy,
    output logic [31:0] data_result,
    output logic        data_exception,
    output logic        data_resultRDY
);
    localparam int unsigned W  = 32;
    localparam int unsigned CW = 6;
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    logic [W-1:0]  m;
    logic [W:0]    a;
    logic [W-1:0]  q;
    logic          q_1;
    logic [CW-1:0] count;

    logic          add_op;
    logic          sub_op;
    logic [W:0]    mx;
    logic [W-1:0]  sum;
    logic          cout;
    logic [W:0]    a_sum;
    logic [W:0]    a_next;
    logic [W-1:0]  q_next;
    logic [W:0]    p_hi;
    logic          ovf;

    assign add_op = ~q[0] & q_1;
    assign sub_op = q[0] & ~q_1;

    // Operand presented to the adder: +M, ~M (with cin=1 for -M), or zero.
    always_comb begin
        mx = '0;
        if (add_op) begin
            mx = {m[W-1], m};
        end else if (sub_op) begin
            mx = ~{m[W-1], m};
        end
    end

    cla_32 u_cla (
        .a    (a[W-1:0]),
        .b    (mx[W-1:0]),
        .cin  (sub_op),
        .sum  (sum),
        .cout (cout)
    );

    // The 33rd accumulator bit keeps -(0x80000000) representable.
    assign a_sum  = {a[W] ^ mx[W] ^ cout, sum};
    assign a_next = {a_sum[W], a_sum[W:1]};
    assign q_next = {a_sum[0], q[W-1:1]};
    assign p_hi   = {a_next[W-1:0], q_next[W-1]};
    assign ovf    = ~((&p_hi) | ~(|p_hi));

    always_ff @(posedge clock) begin
        if (reset) begin
            m              <= '0;
            a              <= '0;
            q              <= '0;
            q_1            <= 1'b0;
            count          <= '0;
            busy           <= 1'b0;
            data_result    <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
        end else begin
            data_resultRDY <= 1'b0;
            if (busy) begin
                a     <= a_next;
                q     <= q_next;
                q_1   <= q[0];
                count <= count + CW'(1);
                if (count == LAST) begin
                    busy           <= 1'b0;
                    data_resultRDY <= 1'b1;
                    data_result    <= q_next;
                    data_exception <= ovf;
                end
            end else if (start) begin
                m     <= data_operandA;
                q     <= data_operandB;
                a     <= '0;
                q_1   <= 1'b0;
                count <= '0;
                busy  <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_mult_booth32.sv
// Directed and randomised checks of mult_booth32 against hand-computed values and a 64-bit product.

module tb_mult_booth32;
    logic        clock;
    logic        reset;
    logic        start;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic        busy;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;

    int checks = 0;
    int errors = 0;

    mult_booth32 dut (
        .clock          (clock),
        .reset          (reset),
        .start          (start),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .busy           (busy),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Pulse start for one cycle, then wait (bounded) for the ready pulse; lat = -1 on timeout.
    task automatic do_mul(input logic [31:0] opa, input logic [31:0] opb,
                          output logic [31:0] res, output logic exc, output int lat);
        data_operandA = opa;
        data_operandB = opb;
        start = 1'b1;
        tick();
        start = 1'b0;
        lat = -1;
        res = 'x;
        exc = 1'bx;
        for (int k = 1; k <= 40; k++) begin
            if (data_resultRDY) begin
                lat = k;
                res = data_result;
                exc = data_exception;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        data_operandA = '0;
        data_operandB = '0;
        tick();
        tick();
        checks++;
        if ({busy, data_resultRDY, data_exception, data_result} !== 35'd0) begin
            errors++;
            $display("FAIL reset_state: busy=%b rdy=%b exc=%b res=%h, expected all 0",
                     busy, data_resultRDY, data_exception, data_result);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic_timing();
        int lat;
        int busy_bad;
        logic [31:0] res;
        logic exc;
        data_operandA = 32'd3;
        data_operandB = 32'd5;
        start = 1'b1;
        tick();
        start = 1'b0;
        lat = -1;
        busy_bad = 0;
        for (int k = 1; k <= 40; k++) begin
            if (k <= 32 && busy !== 1'b1) busy_bad++;
            if (data_resultRDY === 1'b1) begin
                lat = k;
                break;
            end
            tick();
        end
        res = data_result;
        exc = data_exception;
        checks++;
        if (lat != 33) begin
            errors++;
            $display("FAIL basic_latency: got %0d, expected 33", lat);
        end
        checks++;
        if (busy_bad != 0) begin
            errors++;
            $display("FAIL basic_busy: %0d cycles in 1..32 with busy low, expected 0", busy_bad);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_busy_done: busy=%b at ready cycle, expected 0", busy);
        end
        checks++;
        if (res !== 32'h0000000F || exc !== 1'b0) begin
            errors++;
            $display("FAIL basic_3x5: res=%h exc=%b, expected 0000000f/0", res, exc);
        end
        tick();
        checks++;
        if (data_resultRDY !== 1'b0 || data_result !== 32'h0000000F) begin
            errors++;
            $display("FAIL basic_pulse_width: rdy=%b res=%h at cycle 34, expected 0/0000000f",
                     data_resultRDY, data_result);
        end
    endtask

    task automatic test_signed();
        logic [31:0] res;
        logic exc;
        int lat;
        do_mul(32'hFFFFFFF9, 32'd6, res, exc, lat);
        checks++;
        if (lat != 33 || res !== 32'hFFFFFFD6 || exc !== 1'b0) begin
            errors++;
            $display("FAIL signed_m7x6: lat=%0d res=%h exc=%b, expected 33/ffffffd6/0", lat, res, exc);
        end
        do_mul(32'h80000000, 32'd1, res, exc, lat);
        checks++;
        if (lat != 33 || res !== 32'h80000000 || exc !== 1'b0) begin
            errors++;
            $display("FAIL signed_minx1: lat=%0d res=%h exc=%b, expected 33/80000000/0", lat, res, exc);
        end
        tick();
    endtask

    task automatic test_overflow();
        logic [31:0] res;
        logic exc;
        int lat;
        do_mul(32'h7FFFFFFF, 32'd2, res, exc, lat);
        checks++;
        if (lat != 33 || res !== 32'hFFFFFFFE || exc !== 1'b1) begin
            errors++;
            $display("FAIL ovf_maxx2: lat=%0d res=%h exc=%b, expected 33/fffffffe/1", lat, res, exc);
        end
        do_mul(32'h80000000, 32'hFFFFFFFF, res, exc, lat);
        checks++;
        if (lat != 33 || res !== 32'h80000000 || exc !== 1'b1) begin
            errors++;
            $display("FAIL ovf_minxm1: lat=%0d res=%h exc=%b, expected 33/80000000/1", lat, res, exc);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [31:0] res;
        logic exc;
        int lat;
        data_operandA = 32'd4;
        data_operandB = 32'd4;
        start = 1'b1;
        tick();
        start = 1'b0;
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            if (k == 10) begin
                data_operandA = 32'd9;
                data_operandB = 32'd9;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (data_resultRDY === 1'b1) begin
                lat = k;
                break;
            end
            tick();
        end
        start = 1'b0;
        checks++;
        if (lat != 33 || data_result !== 32'h00000010) begin
            errors++;
            $display("FAIL ignore_start: lat=%0d res=%h, expected 33/00000010", lat, data_result);
        end
        do_mul(32'd2, 32'hFFFFFFFD, res, exc, lat);
        checks++;
        if (lat != 33 || res !== 32'hFFFFFFFA || exc !== 1'b0) begin
            errors++;
            $display("FAIL back_to_back: lat=%0d res=%h exc=%b, expected 33/fffffffa/0", lat, res, exc);
        end
        tick();
    endtask

    task automatic test_reset_abort();
        logic [31:0] res;
        logic exc;
        int lat;
        int rdy_seen;
        data_operandA = 32'h00001234;
        data_operandB = 32'h00000010;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k < 15; k++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if ({busy, data_resultRDY, data_exception, data_result} !== 35'd0) begin
            errors++;
            $display("FAIL reset_abort_state: busy=%b rdy=%b exc=%b res=%h, expected all 0",
                     busy, data_resultRDY, data_exception, data_result);
        end
        rdy_seen = 0;
        for (int k = 0; k < 40; k++) begin
            if (data_resultRDY !== 1'b0 || busy !== 1'b0) rdy_seen++;
            tick();
        end
        checks++;
        if (rdy_seen != 0) begin
            errors++;
            $display("FAIL reset_abort_quiet: %0d cycles with rdy/busy after reset, expected 0", rdy_seen);
        end
        do_mul(32'hFFFFFFFF, 32'hFFFFFFFF, res, exc, lat);
        checks++;
        if (lat != 33 || res !== 32'h00000001 || exc !== 1'b0) begin
            errors++;
            $display("FAIL reset_restart: lat=%0d res=%h exc=%b, expected 33/00000001/0", lat, res, exc);
        end
        tick();
    endtask

    task automatic test_random();
        logic [31:0] ra;
        logic [31:0] rb;
        logic [31:0] res;
        logic exc;
        logic [32:0] hi;
        logic exp_exc;
        longint prod;
        int lat;
        for (int n = 0; n < 250; n++) begin
            ra = $urandom();
            rb = $urandom();
            if (n % 4 == 1) rb = $urandom_range(0, 1000) - 500;
            if (n % 8 == 2) ra = ra >>> 16;
            prod = longint'($signed(ra)) * longint'($signed(rb));
            hi = prod[63:31];
            exp_exc = !((hi == 33'd0) || (&hi));
            do_mul(ra, rb, res, exc, lat);
            checks++;
            if (lat != 33 || res !== prod[31:0] || exc !== exp_exc) begin
                errors++;
                $display("FAIL random_%0d: %h*%h lat=%0d res=%h exc=%b, expected 33/%h/%b",
                         n, ra, rb, lat, res, exc, prod[31:0], exp_exc);
            end
            tick();
            tick();
            checks++;
            if (data_result !== prod[31:0] || data_exception !== exp_exc || data_resultRDY !== 1'b0) begin
                errors++;
                $display("FAIL random_hold_%0d: res=%h exc=%b rdy=%b, expected %h/%b/0",
                         n, data_result, data_exception, data_resultRDY, prod[31:0], exp_exc);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_timing();
        test_signed();
        test_overflow();
        test_back_to_back();
        test_reset_abort();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
